sorter_merge_n: RTL and testbench

- Parametrised multi-beat sorter for the V2V demapper path; successor to the fixed QPSK/QAM16 sorter.
- Accepts 4 unsigned values per beat and sorts each beat with an internal 4-input network.
- Merges each sorted beat into a registered running list.
- After 1, 2, 4 or 8 beats (selected by M), presents the fully sorted list with a one-cycle done pulse.

---
 rtl/sorter_merge_n.sv | 147 ++++++++++++++
 tb/tb_sorter_merge_n.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sorter_merge_n.sv
// Multi-beat sorter: sorts 4 unsigned values per beat and rank-merges each beat
// into a registered ascending list; presents the list with a done pulse after 2^M beats.
//
// state  | meaning
// IDLE   | waiting for start; y holds the last result
// LOAD   | accepting beats, merging each into the running list
// DONE   | one-cycle done pulse, result complete on y
module sorter_merge_n #(
    parameter int WIDTH       = 16,
    parameter int MAX_BEATS   = 4,
    parameter int NUM_OUTPUTS = 4*MAX_BEATS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   M,
    input  logic [WIDTH-1:0]             d1,
    input  logic [WIDTH-1:0]             d2,
    input  logic [WIDTH-1:0]             d3,
    input  logic [WIDTH-1:0]             d4,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [NUM_OUTPUTS*WIDTH-1:0] y
);

    localparam int N   = NUM_OUTPUTS;
    localparam int AW  = $clog2(N);
    localparam int CW  = AW + 1;
    localparam int BCW = $clog2(MAX_BEATS) + 1;
    localparam logic [4:0] MAXB = 5'(MAX_BEATS);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       mode_q;
    logic [CW-1:0]    cnt_q;
    logic [BCW-1:0]   beat_q;
    logic             err_q, err_d;
    logic [WIDTH-1:0] list_q [N];
    logic [WIDTH-1:0] merged [N];

    logic [3:0] beats_req, beats_mode;
    logic       mode_ok, last_beat, start_ok, accept;

    assign beats_req  = 4'd1 << M;
    assign beats_mode = 4'd1 << mode_q;
    assign mode_ok    = ({1'b0, beats_req} <= MAXB);
    assign last_beat  = (4'(beat_q) == (beats_mode - 4'd1));
    assign start_ok   = (state_q == S_IDLE) && start && mode_ok;
    assign accept     = (state_q == S_LOAD) && in_valid;

    // Fixed 4-input sorting network (5 compare-exchange elements)
    logic [WIDTH-1:0] a0, a1, a2, a3, b0, b1, b2, b3;
    logic [WIDTH-1:0] s [4];

    assign a0 = (d2 < d1) ? d2 : d1;
    assign a1 = (d2 < d1) ? d1 : d2;
    assign a2 = (d4 < d3) ? d4 : d3;
    assign a3 = (d4 < d3) ? d3 : d4;
    assign b0 = (a2 < a0) ? a2 : a0;
    assign b2 = (a2 < a0) ? a0 : a2;
    assign b1 = (a3 < a1) ? a3 : a1;
    assign b3 = (a3 < a1) ? a1 : a3;
    assign s[0] = b0;
    assign s[1] = (b2 < b1) ? b2 : b1;
    assign s[2] = (b2 < b1) ? b1 : b2;
    assign s[3] = b3;

    logic [CW-1:0] pos_old [N];
    logic [CW-1:0] pos_new [4];

    // Rank placement: ties keep existing entries ahead of the incoming beat
    always_comb begin
        for (int i = 0; i < N; i++) begin
            pos_old[i] = CW'(i);
            for (int j = 0; j < 4; j++)
                if (s[j] < list_q[i]) pos_old[i] = pos_old[i] + CW'(1);
        end
        for (int j = 0; j < 4; j++) begin
            pos_new[j] = CW'(j);
            for (int i = 0; i < N; i++)
                if ((CW'(i) < cnt_q) && (list_q[i] <= s[j])) pos_new[j] = pos_new[j] + CW'(1);
        end
        for (int k = 0; k < N; k++) merged[k] = '0;
        for (int i = 0; i < N; i++)
            if ((CW'(i) < cnt_q) && (pos_old[i] < CW'(N))) merged[pos_old[i][AW-1:0]] = list_q[i];
        for (int j = 0; j < 4; j++)
            if (pos_new[j] < CW'(N)) merged[pos_new[j][AW-1:0]] = s[j];
    end

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (mode_ok) state_d = S_LOAD;
                    else         err_d   = 1'b1;
                end
            end
            S_LOAD:  if (in_valid && last_beat) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= '0;
            cnt_q  <= '0;
            beat_q <= '0;
            for (int k = 0; k < N; k++) list_q[k] <= '0;
        end else if (start_ok) begin
            mode_q <= M;
            cnt_q  <= '0;
            beat_q <= '0;
            for (int k = 0; k < N; k++) list_q[k] <= '0;
        end else if (accept) begin
            cnt_q  <= cnt_q + CW'(4);
            beat_q <= beat_q + BCW'(1);
            for (int k = 0; k < N; k++) list_q[k] <= merged[k];
        end
    end

    assign in_ready = (state_q == S_LOAD);
    assign busy     = (state_q == S_LOAD);
    assign done     = (state_q == S_DONE);
    assign err      = err_q;

    for (genvar k = 0; k < N; k++) begin : g_y
        assign y[k*WIDTH +: WIDTH] = list_q[k];
    end

endmodule

// File: tb/tb_sorter_merge_n.sv
// Self-checking bench for sorter_merge_n: directed scenarios plus randomized sorts
// compared against a queue-sort reference model.
module tb_sorter_merge_n;

    localparam int W  = 16;
    localparam int MB = 4;
    localparam int N  = 4*MB;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [1:0]     m;
    logic [W-1:0]   d1, d2, d3, d4;
    logic           in_valid;
    logic           in_ready, busy, done, err;
    logic [N*W-1:0] y;

    int n_chk  = 0;
    int n_pass = 0;

    sorter_merge_n #(.WIDTH(W), .MAX_BEATS(MB), .NUM_OUTPUTS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .M(m),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4),
        .in_valid(in_valid), .in_ready(in_ready), .busy(busy),
        .done(done), .err(err), .y(y)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] model(input logic [W-1:0] vals[$]);
        logic [W-1:0]   q[$];
        logic [N*W-1:0] r;
        q = vals;
        q.sort();
        r = '0;
        foreach (q[k]) r[k*W +: W] = q[k];
        return r;
    endfunction

    task automatic start_sort(input logic [1:0] mode);
        start = 1'b1;
        m     = mode;
        step();
        start = 1'b0;
    endtask

    task automatic feed_beat(input logic [W-1:0] a, b, c, e, input int gap);
        in_valid = 1'b0;
        repeat (gap) step();
        d1 = a; d2 = b; d3 = c; d4 = e;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; m = '0; in_valid = 1'b0;
        d1 = '0; d2 = '0; d3 = '0; d4 = '0;
        repeat (2) step();
        n_chk++;
        if ({in_ready, busy, done, err} !== 4'b0000 || y !== '0)
            $display("FAIL reset_outputs: ready/busy/done/err=%b y=%h, required 0000 and y=0",
                     {in_ready, busy, done, err}, y);
        else n_pass++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_beat();
        logic [W-1:0] v[$];
        v = '{16'd9, 16'd3, 16'd7, 16'd1};
        start_sort(2'd0);
        n_chk++;
        if (done !== 1'b0 || in_ready !== 1'b1) $display("FAIL m0_load: done=%b ready=%b, required 0 1", done, in_ready);
        else n_pass++;
        feed_beat(16'd9, 16'd3, 16'd7, 16'd1, 0);
        n_chk++;
        if (done !== 1'b1) $display("FAIL m0_latency: done=%b, required 1", done);
        else n_pass++;
        n_chk++;
        if (y !== model(v)) $display("FAIL m0_result: y=%h, required %h", y, model(v));
        else n_pass++;
        n_chk++;
        if (in_ready !== 1'b0) $display("FAIL m0_ready_after: in_ready=%b, required 0", in_ready);
        else n_pass++;
        step();
        n_chk++;
        if (done !== 1'b0 || y !== model(v)) $display("FAIL m0_pulse_hold: done=%b y=%h, required 0 %h", done, y, model(v));
        else n_pass++;
    endtask

    task automatic test_gaps();
        logic [W-1:0] v[$];
        int gaps[4] = '{0, 0, 2, 1};
        int n_done = 0;
        bit busy_ok = 1'b1;
        for (int k = 1; k <= 16; k++) v.push_back(W'(k));
        start_sort(2'd2);
        for (int b = 0; b < 4; b++) begin
            in_valid = 1'b0;
            for (int g = 0; g < gaps[b]; g++) begin
                if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
                step();
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            feed_beat(W'(16-4*b), W'(15-4*b), W'(14-4*b), W'(13-4*b), 0);
            if (done) n_done++;
            if (b < 3 && busy !== 1'b1) busy_ok = 1'b0;
        end
        n_chk++;
        if (y !== model(v)) $display("FAIL gaps_result: y=%h, required %h", y, model(v));
        else n_pass++;
        n_chk++;
        if (busy !== 1'b0 || !busy_ok) $display("FAIL gaps_busy: busy_now=%b busy_ok=%b, required 0 1", busy, busy_ok);
        else n_pass++;
        repeat (3) begin step(); if (done) n_done++; end
        n_chk++;
        if (n_done !== 1) $display("FAIL gaps_done_count: got %0d pulses, required 1", n_done);
        else n_pass++;
    endtask

    task automatic test_duplicates();
        logic [W-1:0] v[$];
        v = '{16'd5, 16'd5, 16'd0, 16'hFFFF, 16'd5, 16'd0, 16'd0, 16'hFFFF};
        start_sort(2'd1);
        feed_beat(16'd5, 16'd5, 16'd0, 16'hFFFF, 0);
        feed_beat(16'd5, 16'd0, 16'd0, 16'hFFFF, 0);
        n_chk++;
        if (done !== 1'b1 || y !== model(v)) $display("FAIL dup_result: done=%b y=%h, required 1 %h", done, y, model(v));
        else n_pass++;
        step();
        n_chk++;
        if (done !== 1'b0) $display("FAIL dup_pulse_width: done=%b, required 0", done);
        else n_pass++;
    endtask

    task automatic test_err();
        logic [N*W-1:0] prev;
        prev = y;
        start_sort(2'd3);
        n_chk++;
        if (err !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || y !== prev)
            $display("FAIL err_pulse: err=%b ready=%b busy=%b y=%h, required 1 0 0 %h", err, in_ready, busy, y, prev);
        else n_pass++;
        step();
        n_chk++;
        if (err !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) $display("FAIL err_width: err=%b done=%b ready=%b, required 0 0 0", err, done, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] v[$];
        int n_done = 0;
        start_sort(2'd2);
        feed_beat(16'd40, 16'd30, 16'd20, 16'd10, 0);
        feed_beat(16'd41, 16'd31, 16'd21, 16'd11, 0);
        rst = 1'b1;
        #1;
        n_chk++;
        if (y !== '0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL midreset_outputs: y=%h busy=%b done=%b ready=%b, required 0", y, busy, done, in_ready);
        else n_pass++;
        step();
        rst = 1'b0;
        repeat (4) begin step(); if (done) n_done++; end
        n_chk++;
        if (n_done !== 0) $display("FAIL midreset_no_done: got %0d pulses, required 0", n_done);
        else n_pass++;
        v = '{16'd4, 16'd2, 16'd3, 16'd1};
        start_sort(2'd0);
        feed_beat(16'd4, 16'd2, 16'd3, 16'd1, 0);
        n_chk++;
        if (done !== 1'b1 || y !== model(v)) $display("FAIL midreset_resort: done=%b y=%h, required 1 %h", done, y, model(v));
        else n_pass++;
        step();
    endtask

    task automatic test_start_held();
        logic [W-1:0] v[$];
        v = '{16'd100, 16'd7, 16'd55, 16'd8};
        start = 1'b1; m = 2'd0;
        step();
        feed_beat(16'd100, 16'd7, 16'd55, 16'd8, 0);
        n_chk++;
        if (done !== 1'b1 || y !== model(v)) $display("FAIL held_first: done=%b y=%h, required 1 %h", done, y, model(v));
        else n_pass++;
        step();
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0 || y !== model(v))
            $display("FAIL held_idle: busy=%b done=%b y=%h, required 0 0 %h", busy, done, y, model(v));
        else n_pass++;
        step();
        n_chk++;
        if (busy !== 1'b1 || y !== '0) $display("FAIL held_restart: busy=%b y=%h, required 1 0", busy, y);
        else n_pass++;
        start = 1'b0;
        feed_beat(16'd1, 16'd1, 16'd1, 16'd1, 0);
        step();
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [W-1:0] v[$];
            logic [W-1:0] bv[4];
            int mode, nb;
            bit part_ok = 1'b1;
            v = {};
            mode = $urandom_range(0, 2);
            nb = 1 << mode;
            start_sort(2'(mode));
            for (int b = 0; b < nb; b++) begin
                for (int j = 0; j < 4; j++) begin
                    bv[j] = (it % 2 == 0) ? W'($urandom_range(0, 7)) : W'($urandom);
                    v.push_back(bv[j]);
                end
                feed_beat(bv[0], bv[1], bv[2], bv[3], $urandom_range(0, 2));
                if (b < nb - 1 && y !== model(v)) part_ok = 1'b0;
            end
            n_chk++;
            if (done !== 1'b1 || y !== model(v))
                $display("FAIL rand_result[%0d] m=%0d: done=%b y=%h, required 1 %h", it, mode, done, y, model(v));
            else n_pass++;
            n_chk++;
            if (!part_ok) $display("FAIL rand_partial[%0d]: partial list differed from model, required match", it);
            else n_pass++;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_gaps();
        test_duplicates();
        test_err();
        test_reset_mid();
        test_start_held();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
